// File: rtl/learning_sequencer.sv
// Learning-mode sequencer: walks a stored song, plays each prompt note, waits for the answer, scores it.
// Latency: one cycle per FETCH/JUDGE/NEXT, prompt length from memory; outputs depend on registered state only.
module learning_sequencer #(
    parameter int              NOTE_W    = 4,
    parameter int              DUR_W     = 26,
    parameter int              ADDR_W    = 5,
    parameter int              SCORE_W   = 7,
    parameter int              MAX_TRIES = 3,
    parameter logic [DUR_W-1:0] TIMEOUT  = DUR_W'(50_000_000)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               exam_mode,
    input  logic [NOTE_W-1:0]  note_value,
    input  logic [DUR_W-1:0]   duration_value,
    input  logic               isvalid,
    input  logic [NOTE_W-1:0]  user_input,
    input  logic               comfirm_button,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               key_on,
    output logic [NOTE_W-1:0]  key,
    output logic               hint_on,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] mistakes,
    output logic               done,
    output logic [2:0]         state
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_PROMPT = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_JUDGE  = 3'd4;
    localparam logic [2:0] S_NEXT   = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    localparam int                 SUM_W     = SCORE_W + 4;
    localparam logic [2:0]         TRIES_MAX = 3'(MAX_TRIES);
    localparam logic [DUR_W-1:0]   TO_LAST   = TIMEOUT - DUR_W'(1);
    localparam logic [SCORE_W-1:0] SCORE_SAT = {SCORE_W{1'b1}};

    logic [2:0]         state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [NOTE_W-1:0]  note_q, note_d;
    logic [NOTE_W-1:0]  ans_q, ans_d;
    logic [DUR_W-1:0]   dur_q, dur_d;
    logic [DUR_W-1:0]   cnt_q, cnt_d;
    logic               timed_out_q, timed_out_d;
    logic [2:0]         tries_q, tries_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [SCORE_W-1:0] mist_q, mist_d;
    logic               exam_q, exam_d;
    logic               hint_q, hint_d;

    logic [DUR_W-1:0]   dur_fetch;
    logic [2:0]         score_inc;
    logic [2:0]         tries_nxt;
    logic [SUM_W-1:0]   score_sum;
    logic               correct;

    always_comb begin
        // a zero-length note would never leave PROMPT, so it plays for one cycle
        dur_fetch = (duration_value == '0) ? DUR_W'(1) : duration_value;
        score_inc = exam_q ? TRIES_MAX : (TRIES_MAX - tries_q);
        tries_nxt = tries_q + 3'd1;
        score_sum = SUM_W'(score_q) + SUM_W'(score_inc);
        correct   = (ans_q == note_q) && !timed_out_q;
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        note_d      = note_q;
        ans_d       = ans_q;
        dur_d       = dur_q;
        cnt_d       = cnt_q;
        timed_out_d = timed_out_q;
        tries_d     = tries_q;
        score_d     = score_q;
        mist_d      = mist_q;
        exam_d      = exam_q;
        hint_d      = hint_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    score_d     = '0;
                    mist_d      = '0;
                    tries_d     = '0;
                    addr_d      = '0;
                    hint_d      = 1'b0;
                    timed_out_d = 1'b0;
                    exam_d      = exam_mode;
                    state_d     = S_FETCH;
                end
            end
            S_FETCH: begin
                note_d = note_value;
                dur_d  = dur_fetch;
                if (!isvalid) begin
                    state_d = S_DONE;
                end else if (exam_q) begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end else begin
                    cnt_d   = dur_fetch;
                    state_d = S_PROMPT;
                end
            end
            S_PROMPT: begin
                if (cnt_q <= DUR_W'(1)) begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end else begin
                    cnt_d = cnt_q - DUR_W'(1);
                end
            end
            S_WAIT: begin
                // a confirm on the last allowed cycle is still taken as an answer
                if (comfirm_button) begin
                    ans_d       = user_input;
                    timed_out_d = 1'b0;
                    state_d     = S_JUDGE;
                end else if (cnt_q == TO_LAST) begin
                    timed_out_d = 1'b1;
                    state_d     = S_JUDGE;
                end else begin
                    cnt_d = cnt_q + DUR_W'(1);
                end
            end
            S_JUDGE: begin
                if (correct) begin
                    score_d = (score_sum > SUM_W'(SCORE_SAT)) ? SCORE_SAT
                                                              : score_sum[SCORE_W-1:0];
                    state_d = S_NEXT;
                end else begin
                    if (mist_q != SCORE_SAT) begin
                        mist_d = mist_q + SCORE_W'(1);
                    end
                    tries_d = tries_nxt;
                    if (!exam_q && (tries_nxt < TRIES_MAX)) begin
                        hint_d  = 1'b1;
                        cnt_d   = dur_q;
                        state_d = S_PROMPT;
                    end else begin
                        state_d = S_NEXT;
                    end
                end
            end
            S_NEXT: begin
                tries_d = '0;
                hint_d  = 1'b0;
                if (&addr_q) begin
                    state_d = S_DONE;
                end else begin
                    addr_d  = addr_q + ADDR_W'(1);
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            note_q      <= '0;
            ans_q       <= '0;
            dur_q       <= '0;
            cnt_q       <= '0;
            timed_out_q <= 1'b0;
            tries_q     <= '0;
            score_q     <= '0;
            mist_q      <= '0;
            exam_q      <= 1'b0;
            hint_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            note_q      <= note_d;
            ans_q       <= ans_d;
            dur_q       <= dur_d;
            cnt_q       <= cnt_d;
            timed_out_q <= timed_out_d;
            tries_q     <= tries_d;
            score_q     <= score_d;
            mist_q      <= mist_d;
            exam_q      <= exam_d;
            hint_q      <= hint_d;
        end
    end

    assign state    = state_q;
    assign mem_addr = addr_q;
    assign key_on   = (state_q == S_PROMPT);
    assign key      = (state_q == S_PROMPT) ? note_q : '0;
    assign hint_on  = hint_q;
    assign score    = score_q;
    assign mistakes = mist_q;
    assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_learning_sequencer.sv
// Directed bench for learning_sequencer: practice, replay, exam, timeout, reset, restart, saturation.
module tb_learning_sequencer;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_PROMPT = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_JUDGE  = 3'd4;
    localparam logic [2:0] S_NEXT   = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    logic       clk = 1'b0;
    logic       rst, start, exam_mode, isvalid, comfirm_button;
    logic [3:0] note_value, user_input, key;
    logic [7:0] duration_value;
    logic [4:0] mem_addr, score, mistakes;
    logic       key_on, hint_on, done;
    logic [2:0] state;

    logic [3:0] m_note [32];
    logic [7:0] m_dur  [32];
    logic       m_vld  [32];

    int checks   = 0;
    int failures = 0;
    int n;

    always #5 clk = ~clk;

    assign note_value     = m_note[mem_addr];
    assign duration_value = m_dur[mem_addr];
    assign isvalid        = m_vld[mem_addr];

    learning_sequencer #(
        .NOTE_W(4), .DUR_W(8), .ADDR_W(5), .SCORE_W(5),
        .MAX_TRIES(3), .TIMEOUT(8'd20)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .exam_mode(exam_mode),
        .note_value(note_value), .duration_value(duration_value), .isvalid(isvalid),
        .user_input(user_input), .comfirm_button(comfirm_button),
        .mem_addr(mem_addr), .key_on(key_on), .key(key), .hint_on(hint_on),
        .score(score), .mistakes(mistakes), .done(done), .state(state)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
        int k = 0;
        while (state !== s && k < budget) begin
            step();
            k++;
        end
        chk(tag, 32'(state), 32'(s));
    endtask

    // confirm an answer in WAIT; returns one cycle after JUDGE
    task automatic answer(input logic [3:0] a);
        wait_state(S_WAIT, 60, "wait_reached");
        user_input     = a;
        comfirm_button = 1'b1;
        step();
        comfirm_button = 1'b0;
        chk("judge_after_confirm", 32'(state), 32'(S_JUDGE));
        step();
    endtask

    task automatic clear_song();
        for (int i = 0; i < 32; i++) begin
            m_note[i] = 4'd0;
            m_dur[i]  = 8'd1;
            m_vld[i]  = 1'b0;
        end
    endtask

    task automatic begin_session(input logic exam);
        exam_mode = exam;
        start     = 1'b1;
        step();
        start     = 1'b0;
        chk("start_to_fetch", 32'(state), 32'(S_FETCH));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; exam_mode = 1'b0;
        user_input = 4'd0; comfirm_button = 1'b0;
        clear_song();
        step();
        step();
        rst = 1'b0;

        chk("rst_state", 32'(state), 32'(S_IDLE));
        chk("rst_key_on", 32'(key_on), 0);
        chk("rst_key", 32'(key), 0);
        chk("rst_score", 32'(score), 0);
        chk("rst_mistakes", 32'(mistakes), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_hint", 32'(hint_on), 0);

        // practice, song {5,2,9}, duration 4, all correct first time
        clear_song();
        m_note[0] = 4'd5; m_note[1] = 4'd2; m_note[2] = 4'd9;
        for (int i = 0; i < 3; i++) begin m_dur[i] = 8'd4; m_vld[i] = 1'b1; end
        begin_session(1'b0);
        chk("t1_keyon_in_fetch", 32'(key_on), 0);
        for (int i = 0; i < 3; i++) begin
            wait_state(S_PROMPT, 10, "t1_prompt");
            chk("t1_key", 32'(key), 32'(m_note[i]));
            n = 0;
            while (key_on === 1'b1 && n < 50) begin n++; step(); end
            chk("t1_keyon_len", n, 4);
            chk("t1_after_prompt", 32'(state), 32'(S_WAIT));
            answer(m_note[i]);
            chk("t1_next", 32'(state), 32'(S_NEXT));
        end
        wait_state(S_DONE, 10, "t1_done_state");
        chk("t1_score", 32'(score), 9);
        chk("t1_mistakes", 32'(mistakes), 0);
        chk("t1_done", 32'(done), 1);
        chk("t1_addr", 32'(mem_addr), 3);
        step();
        chk("t1_hold_score", 32'(score), 9);

        // practice replays: note 5 answered 3,3,5 then note 5 answered 3,3,3
        clear_song();
        m_note[0] = 4'd5; m_dur[0] = 8'd2; m_vld[0] = 1'b1;
        m_note[1] = 4'd5; m_dur[1] = 8'd2; m_vld[1] = 1'b1;
        begin_session(1'b0);
        chk("t2_restart_score", 32'(score), 0);
        chk("t2_restart_addr", 32'(mem_addr), 0);
        answer(4'd3);
        chk("t2_replay1", 32'(state), 32'(S_PROMPT));
        chk("t2_hint1", 32'(hint_on), 1);
        chk("t2_mist1", 32'(mistakes), 1);
        answer(4'd3);
        chk("t2_replay2", 32'(state), 32'(S_PROMPT));
        chk("t2_mist2", 32'(mistakes), 2);
        answer(4'd5);
        chk("t2_score_third_try", 32'(score), 1);
        chk("t2_next_after_ok", 32'(state), 32'(S_NEXT));
        step();
        chk("t2_hint_cleared", 32'(hint_on), 0);
        answer(4'd3);
        answer(4'd3);
        chk("t2_mist4", 32'(mistakes), 4);
        answer(4'd3);
        chk("t2_give_up", 32'(state), 32'(S_NEXT));
        chk("t2_mist5", 32'(mistakes), 5);
        chk("t2_score_unchanged", 32'(score), 1);
        wait_state(S_DONE, 10, "t2_done_state");
        chk("t2_addr", 32'(mem_addr), 2);

        // exam mode: no prompt, no replay; start during WAIT ignored
        clear_song();
        m_note[0] = 4'd7; m_dur[0] = 8'd3; m_vld[0] = 1'b1;
        m_note[1] = 4'd4; m_dur[1] = 8'd3; m_vld[1] = 1'b1;
        begin_session(1'b1);
        step();
        chk("t3_no_prompt", 32'(state), 32'(S_WAIT));
        chk("t3_keyon_off", 32'(key_on), 0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t3_start_ignored", 32'(state), 32'(S_WAIT));
        answer(4'd1);
        chk("t3_wrong_next", 32'(state), 32'(S_NEXT));
        chk("t3_mist", 32'(mistakes), 1);
        chk("t3_no_hint", 32'(hint_on), 0);
        answer(4'd4);
        chk("t3_score", 32'(score), 3);
        wait_state(S_DONE, 10, "t3_done_state");

        // timeout at 20 cycles, then confirm on the 20th cycle wins
        clear_song();
        m_note[0] = 4'd6; m_vld[0] = 1'b1;
        m_note[1] = 4'd6; m_vld[1] = 1'b1;
        begin_session(1'b1);
        user_input = 4'd6;
        step();
        repeat (19) step();
        chk("t4_still_wait", 32'(state), 32'(S_WAIT));
        step();
        chk("t4_timeout_judge", 32'(state), 32'(S_JUDGE));
        step();
        chk("t4_timeout_miss", 32'(mistakes), 1);
        chk("t4_timeout_noscore", 32'(score), 0);
        step();
        step();
        chk("t4_wait2", 32'(state), 32'(S_WAIT));
        repeat (19) step();
        comfirm_button = 1'b1;
        step();
        comfirm_button = 1'b0;
        chk("t4_confirm_judge", 32'(state), 32'(S_JUDGE));
        step();
        chk("t4_confirm_scored", 32'(score), 3);
        chk("t4_confirm_mist", 32'(mistakes), 1);
        wait_state(S_DONE, 10, "t4_done_state");

        // reset mid-prompt during a replay
        clear_song();
        m_note[0] = 4'd5; m_dur[0] = 8'd6; m_vld[0] = 1'b1;
        begin_session(1'b0);
        answer(4'd3);
        chk("t5_replay", 32'(state), 32'(S_PROMPT));
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_state", 32'(state), 32'(S_IDLE));
        chk("t5_key_on", 32'(key_on), 0);
        chk("t5_key", 32'(key), 0);
        chk("t5_hint", 32'(hint_on), 0);
        chk("t5_mist", 32'(mistakes), 0);
        chk("t5_done", 32'(done), 0);

        // full 32-entry exam song: score saturates at 31, address stops at 31
        clear_song();
        for (int i = 0; i < 32; i++) begin
            m_note[i] = 4'(i);
            m_vld[i]  = 1'b1;
        end
        begin_session(1'b1);
        for (int i = 0; i < 32; i++) begin
            answer(m_note[i]);
            if (i == 9) chk("t6_score_30", 32'(score), 30);
        end
        wait_state(S_DONE, 10, "t6_done_state");
        chk("t6_score_sat", 32'(score), 31);
        chk("t6_mist", 32'(mistakes), 0);
        chk("t6_addr", 32'(mem_addr), 31);
        step();
        chk("t6_addr_hold", 32'(mem_addr), 31);
        chk("t6_done", 32'(done), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
